// File: rtl/uart_receiver.sv
// UART receive stage: synchronises the RX line, frames start/data/parity/stop
// bits by oversampling with the baud tick, and presents the character, raw
// parity bit and frame-error flag with a one-cycle done pulse.
module uart_receiver #(
    parameter int unsigned OVS_RATE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       baud_rt_tick_i,
    input  logic       rx_i,
    input  logic [1:0] data_width_i,
    input  logic [1:0] parity_mode_i,
    input  logic [1:0] stop_bits_i,
    output logic [7:0] data_rx_o,
    output logic       parity_o,
    output logic       frame_error_o,
    output logic       rx_done_o,
    output logic       is_receiving_o
);

    localparam int unsigned TickW = $clog2(OVS_RATE);
    localparam logic [TickW-1:0] HalfTick = TickW'(OVS_RATE / 2 - 1);
    localparam logic [TickW-1:0] FullTick = TickW'(OVS_RATE - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone} state_e;

    state_e           state_q;
    logic             rx_meta_q, rx_s_q, rx_prev_q;
    logic [TickW-1:0] tick_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [1:0]       width_q;
    logic             par_en_q, stop2_q;
    logic [7:0]       shreg_q;
    logic             par_q, ferr_q;

    logic fall_edge, half_hit, full_hit, last_data, last_stop;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Sample-point and end-of-field decodes.
    always_comb begin
        fall_edge = rx_prev_q & ~rx_s_q;
        half_hit  = baud_rt_tick_i && (tick_cnt_q == HalfTick);
        full_hit  = baud_rt_tick_i && (tick_cnt_q == FullTick);
        last_data = (bit_cnt_q == (3'(width_q) + 3'd4));
        last_stop = (bit_cnt_q == {2'b00, stop2_q});
    end

    // Frame FSM with counters, shift register and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            tick_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            width_q        <= '0;
            par_en_q       <= 1'b0;
            stop2_q        <= 1'b0;
            shreg_q        <= '0;
            par_q          <= 1'b0;
            ferr_q         <= 1'b0;
            data_rx_o      <= '0;
            parity_o       <= 1'b0;
            frame_error_o  <= 1'b0;
            rx_done_o      <= 1'b0;
            is_receiving_o <= 1'b0;
        end else begin
            rx_done_o <= 1'b0;
            if (baud_rt_tick_i) begin
                tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
            unique case (state_q)
                StIdle: begin
                    tick_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    if (fall_edge) begin
                        state_q        <= StStart;
                        width_q        <= data_width_i;
                        par_en_q       <= ~parity_mode_i[1];
                        stop2_q        <= (stop_bits_i == 2'b01);
                        shreg_q        <= '0;
                        par_q          <= 1'b0;
                        ferr_q         <= 1'b0;
                        is_receiving_o <= 1'b1;
                    end
                end
                StStart: begin
                    if (half_hit) begin
                        tick_cnt_q <= '0;
                        if (rx_s_q) begin
                            // False start: back to idle, outputs untouched.
                            state_q        <= StIdle;
                            is_receiving_o <= 1'b0;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (full_hit) begin
                        tick_cnt_q         <= '0;
                        shreg_q[bit_cnt_q] <= rx_s_q;
                        if (last_data) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? StParity : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                StParity: begin
                    if (full_hit) begin
                        tick_cnt_q <= '0;
                        par_q      <= rx_s_q;
                        state_q    <= StStop;
                    end
                end
                StStop: begin
                    if (full_hit) begin
                        tick_cnt_q <= '0;
                        if (!rx_s_q) begin
                            ferr_q <= 1'b1;
                        end
                        if (last_stop) begin
                            // Outputs load on DONE entry so they are valid with the pulse.
                            state_q        <= StDone;
                            is_receiving_o <= 1'b0;
                            data_rx_o      <= shreg_q;
                            parity_o       <= par_q;
                            frame_error_o  <= ferr_q | ~rx_s_q;
                            rx_done_o      <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                StDone: begin
                    tick_cnt_q <= '0;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of directed frames plus
// hand-written reset, glitch, break and mid-frame configuration sequences.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] data_width = 2'b11;
    logic [1:0] parity_mode = 2'b10;
    logic [1:0] stop_bits = 2'b00;
    logic [7:0] data_rx;
    logic       parity, frame_error, rx_done, is_receiving;

    int passed = 0;
    int total = 0;

    uart_receiver #(.OVS_RATE(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .baud_rt_tick_i (tick),
        .rx_i           (rx),
        .data_width_i   (data_width),
        .parity_mode_i  (parity_mode),
        .stop_bits_i    (stop_bits),
        .data_rx_o      (data_rx),
        .parity_o       (parity),
        .frame_error_o  (frame_error),
        .rx_done_o      (rx_done),
        .is_receiving_o (is_receiving)
    );

    always #5 clk = ~clk;

    // Baud tick every other clock, changed just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick = ~tick;
        end
    end

    // Monitor: count done pulses, capture outputs and ticks spent receiving.
    int         done_cnt = 0;
    logic [7:0] cap_data = '0;
    logic       cap_par = 1'b0;
    logic       cap_ferr = 1'b0;
    int         frame_ticks = 0;
    int         cap_ticks = 0;
    logic       recv_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt  <= done_cnt + 1;
            cap_data  <= data_rx;
            cap_par   <= parity;
            cap_ferr  <= frame_error;
            cap_ticks <= recv_prev ? frame_ticks : 0;
        end
        if (is_receiving && !recv_prev) begin
            frame_ticks <= tick ? 1 : 0;
        end else if (is_receiving && tick) begin
            frame_ticks <= frame_ticks + 1;
        end
        recv_prev <= is_receiving;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bit period = 16 ticks = 32 clocks.
    task automatic send_bit(input logic b);
        rx = b;
        step(32);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                              input logic pbit, input int nstop, input logic [1:0] stops);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (has_par) send_bit(pbit);
        for (int i = 0; i < nstop; i++) send_bit(stops[i]);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [1:0] w;
        logic [1:0] pm;
        logic [1:0] sb;
        logic [7:0] d;
        logic       pbit;
        logic [1:0] stops;   // bit0 = first stop bit on the line
        logic [7:0] e_data;
        logic       e_par;
        logic       e_ferr;
        int         e_ticks; // ticks from START entry to final stop sample
    } vec_t;

    vec_t vecs[7];
    int   d0;

    initial begin
        vecs[0] = '{2'b11, 2'b10, 2'b00, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0, 152};
        vecs[1] = '{2'b10, 2'b00, 2'b00, 8'h55, 1'b0, 2'b11, 8'h55, 1'b0, 1'b0, 152};
        vecs[2] = '{2'b10, 2'b01, 2'b00, 8'h55, 1'b1, 2'b11, 8'h55, 1'b1, 1'b0, 152};
        vecs[3] = '{2'b00, 2'b10, 2'b01, 8'h1F, 1'b0, 2'b01, 8'h1F, 1'b0, 1'b1, 120};
        vecs[4] = '{2'b00, 2'b10, 2'b01, 8'h03, 1'b0, 2'b11, 8'h03, 1'b0, 1'b0, 120};
        vecs[5] = '{2'b01, 2'b00, 2'b10, 8'h2A, 1'b1, 2'b11, 8'h2A, 1'b1, 1'b0, 136};
        vecs[6] = '{2'b11, 2'b10, 2'b00, 8'h81, 1'b0, 2'b10, 8'h81, 1'b0, 1'b1, 152};

        // Reset state
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset data_rx", int'(data_rx), 0);
        check("reset parity", int'(parity), 0);
        check("reset frame_error", int'(frame_error), 0);
        check("reset rx_done", int'(rx_done), 0);
        check("reset is_receiving", int'(is_receiving), 0);
        step(10);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            data_width  = vecs[i].w;
            parity_mode = vecs[i].pm;
            stop_bits   = vecs[i].sb;
            step(4);
            d0 = done_cnt;
            send_frame(vecs[i].d, int'(vecs[i].w) + 5, !vecs[i].pm[1], vecs[i].pbit,
                       (vecs[i].sb == 2'b01) ? 2 : 1, vecs[i].stops);
            step(40);
            check($sformatf("vec%0d done pulses", i), done_cnt - d0, 1);
            check($sformatf("vec%0d data", i), int'(cap_data), int'(vecs[i].e_data));
            check($sformatf("vec%0d parity", i), int'(cap_par), int'(vecs[i].e_par));
            check($sformatf("vec%0d frame_error", i), int'(cap_ferr), int'(vecs[i].e_ferr));
            check($sformatf("vec%0d ticks", i), cap_ticks, vecs[i].e_ticks);
        end

        // Reset during data bit 3 of a 0x3C frame (bit3 is 1, so the line stays high)
        data_width = 2'b11; parity_mode = 2'b10; stop_bits = 2'b00;
        step(4);
        d0 = done_cnt;
        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        rx = 1'b1;
        step(16);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("midreset data_rx", int'(data_rx), 0);
        check("midreset parity", int'(parity), 0);
        check("midreset frame_error", int'(frame_error), 0);
        check("midreset rx_done", int'(rx_done), 0);
        check("midreset is_receiving", int'(is_receiving), 0);
        step(400);
        check("midreset no done", done_cnt - d0, 0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 2'b11);
        step(40);
        check("post-reset done pulses", done_cnt - d0, 1);
        check("post-reset data", int'(cap_data), 'h3C);
        check("post-reset frame_error", int'(cap_ferr), 0);

        // Glitch: 4 ticks low, then high
        d0 = done_cnt;
        rx = 1'b0;
        step(6);
        check("glitch start entered", int'(is_receiving), 1);
        step(2);
        rx = 1'b1;
        step(20);
        check("glitch back to idle", int'(is_receiving), 0);
        step(300);
        check("glitch no done", done_cnt - d0, 0);

        // Break: line low for three frame times
        d0 = done_cnt;
        rx = 1'b0;
        step(960);
        check("break done pulses", done_cnt - d0, 1);
        check("break data", int'(cap_data), 0);
        check("break frame_error", int'(cap_ferr), 1);
        check("break no retrigger", int'(is_receiving), 0);
        rx = 1'b1;
        step(100);
        check("break after release", done_cnt - d0, 1);

        // Width change during bit 2 of an 8N1 frame of 0xC3
        d0 = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1);
        rx = 1'b0;
        step(16);
        data_width = 2'b00;
        step(16);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b1);
        step(40);
        check("cfgchg done pulses", done_cnt - d0, 1);
        check("cfgchg data", int'(cap_data), 'hC3);
        check("cfgchg ticks", cap_ticks, 152);
        send_frame(8'h15, 5, 1'b0, 1'b0, 1, 2'b11);
        step(40);
        check("cfgchg next data", int'(cap_data), 'h15);
        check("cfgchg next ticks", cap_ticks, 104);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
